// File: rtl/counter_modulo_prog.sv
// counter_modulo_prog: runtime-programmable modulo counter with up/down
// counting, synchronous load, continuous / one-shot modes and a registered
// terminal-count pulse for cascading.
//
// Optional feature macro: COUNTER_WRAP_COUNT_EN
//   When defined, adds the WRAP_WIDTH parameter and the wrap_count output,
//   a saturating count of wraps since the last start (cleared on start,
//   kept across loads).
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   enable       one count step per cycle while RUN
//   start        latch modulus/mode/dir, initialise counter, enter RUN
//   stop         abort to IDLE, counter held (highest priority)
//   mode         0 continuous, 1 one-shot (latched on start)
//   dir          0 up, 1 down (latched on start)
//   load         synchronous load of load_value (clamped to Meff-1)
//   load_value   value for load
//   modulus      M, 0 means full 2^CNT_WIDTH range (latched on start)
//   counter_out  registered count
//   tc           registered one-cycle wrap pulse
//   busy         high in RUN
//   done         one-cycle pulse at the end of a one-shot run
module counter_modulo_prog #(
  parameter int CNT_WIDTH = 8
`ifdef COUNTER_WRAP_COUNT_EN
  , parameter int WRAP_WIDTH = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic                 dir,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic [CNT_WIDTH-1:0] modulus,
  output logic [CNT_WIDTH-1:0] counter_out,
  output logic                 tc,
  output logic                 busy,
  output logic                 done
`ifdef COUNTER_WRAP_COUNT_EN
  , output logic [WRAP_WIDTH-1:0] wrap_count
`endif
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  // One bit wider than the counter so Meff = 2^CNT_WIDTH is representable.
  typedef logic [CNT_WIDTH:0]   ext_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  cnt_t   mod_q, mod_d;
  logic   mode_q, mode_d;
  logic   dir_q, dir_d;
  logic   tc_q, tc_d;

  ext_t meff_q, meff_new, meff_sel;
  cnt_t last_q, last_new, clamp_val;

  function automatic ext_t to_meff(cnt_t m);
    return (m == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, m};
  endfunction

  always_comb begin
    meff_q   = to_meff(mod_q);
    meff_new = to_meff(modulus);
    last_q   = cnt_t'(meff_q - ext_t'(1));
    last_new = cnt_t'(meff_new - ext_t'(1));
    // A load coinciding with start is clamped against the modulus being latched.
    meff_sel  = start ? meff_new : meff_q;
    clamp_val = ({1'b0, load_value} < meff_sel) ? load_value
                                                : cnt_t'(meff_sel - ext_t'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      if (start) begin
        mod_d   = modulus;
        mode_d  = mode;
        dir_d   = dir;
        state_d = RUN;
        cnt_d   = dir ? last_new : '0;
      end else if (state_q == DONE) begin
        state_d = IDLE;
      end

      if (load) begin
        cnt_d = clamp_val;
      end else if (!start && state_q == RUN && enable) begin
        if (dir_q ? (cnt_q == '0) : (cnt_q == last_q)) begin
          tc_d = 1'b1;
          // One-shot parks on the terminal value; continuous wraps around.
          if (mode_q) state_d = DONE;
          else        cnt_d   = dir_q ? last_q : '0;
        end else begin
          cnt_d = dir_q ? cnt_q - cnt_t'(1) : cnt_q + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mod_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

`ifdef COUNTER_WRAP_COUNT_EN
  logic [WRAP_WIDTH-1:0] wrap_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      wrap_q <= '0;
    else if (start && !stop)        wrap_q <= '0;
    else if (tc_d && wrap_q != '1)  wrap_q <= wrap_q + WRAP_WIDTH'(1);
  end
  assign wrap_count = wrap_q;
`endif

  assign counter_out = cnt_q;
  assign tc          = tc_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_counter_modulo_prog.sv
module tb_counter_modulo_prog;
  logic       clk = 1'b0;
  logic       reset, enable, start, stop, mode, dir, load;
  logic [7:0] load_value, modulus;
  logic [7:0] counter_out;
  logic       tc, busy, done;
`ifdef COUNTER_WRAP_COUNT_EN
  logic [7:0] wrap_count;
`endif

  int checks = 0;
  int failures = 0;

  counter_modulo_prog dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .dir(dir), .load(load), .load_value(load_value),
    .modulus(modulus), .counter_out(counter_out), .tc(tc), .busy(busy),
    .done(done)
`ifdef COUNTER_WRAP_COUNT_EN
    , .wrap_count(wrap_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int c, input bit t, input bit b);
    chk({tag, "_cnt"},  counter_out, c);
    chk({tag, "_tc"},   tc, t);
    chk({tag, "_busy"}, busy, b);
  endtask

  int up_seq [12] = '{0,1,2,3,4,0,1,2,3,4,0,1};

  initial begin
    reset = 1; enable = 0; start = 0; stop = 0; mode = 0; dir = 0; load = 0;
    load_value = 0; modulus = 0;
    #12;
    chk3("rst", 0, 0, 0);
    chk("rst_done", done, 0);
    reset = 0;

    // Continuous up, M=5.
    modulus = 5; mode = 0; dir = 0; start = 1; enable = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      start = 0;
      chk3($sformatf("up%0d", i), up_seq[i], (i == 5 || i == 10), 1);
    end
`ifdef COUNTER_WRAP_COUNT_EN
    chk("wrap_count", wrap_count, 2);
`endif

    // Reset asynchronously mid-run at counter=3.
    tick(); tick();
    chk("pre_rst_cnt", counter_out, 3);
    #2 reset = 1;
    #1 chk3("async_rst", 0, 0, 0);
    #1 reset = 0;

    // One-shot down, M=3.
    modulus = 3; dir = 1; mode = 1; start = 1; enable = 1;
    tick(); start = 0;
    chk3("os0", 2, 0, 1);
    tick(); chk3("os1", 1, 0, 1);
    tick(); chk3("os2", 0, 0, 1);
    tick(); chk3("os3", 0, 1, 0);
    chk("os3_done", done, 1);
    tick(); chk3("os4", 0, 0, 0);
    chk("os4_done", done, 0);

    // Full range from a load that coincides with start.
    modulus = 0; mode = 0; dir = 0; start = 1; load = 1; load_value = 254;
    tick(); start = 0; load = 0;
    chk3("fr0", 254, 0, 1);
    tick(); chk3("fr1", 255, 0, 1);
    tick(); chk3("fr2", 0, 1, 1);

    // M=1: every enabled step is a wrap.
    modulus = 1; start = 1;
    tick(); start = 0;
    chk3("m1_0", 0, 0, 1);
    tick(); chk3("m1_1", 0, 1, 1);
    tick(); chk3("m1_2", 0, 1, 1);
    enable = 0;
    tick(); chk3("m1_off", 0, 0, 1);

    // Load clamp and ignored modulus change while running.
    modulus = 10; enable = 1; start = 1;
    tick(); start = 0;
    chk3("ld0", 0, 0, 1);
    modulus = 3; load = 1; load_value = 20;
    tick(); load = 0;
    chk3("ld_clamp", 9, 0, 1);
    tick(); chk3("ld_wrap", 0, 1, 1);
    tick(); tick(); tick();
    chk3("ld_nowrap3", 3, 0, 1);

    // stop beats load and start.
    enable = 0; stop = 1; load = 1; load_value = 7; start = 1;
    tick(); stop = 0; load = 0; start = 0;
    chk3("stop", 3, 0, 0);
    tick(); chk3("idle_hold", 3, 0, 0);
    start = 1;
    tick(); start = 0;
    chk3("restart", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
